alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Shares the single registered ALU between two requesters (e.g. decode and address-gen) using round-robin arbitration.
- Sequences each accepted operation through the ALU's one-cycle registered pipeline, then returns the 32-bit result to the granted requester over a valid/ready response channel.
- Illegal opcodes are rejected with an error response; they are never issued to the ALU.

Parameters:
- OPND_W, 5, operand width; matches ALU operand ports.
- RES_W, 32, result width; matches ALU result port.
- NREQ, 2, number of requesters; fixed at 2 for this revision.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_op_a  in  NREQ*OPND_W  operand 1 per requester; requester i uses slice i.
- req_op_b  in  NREQ*OPND_W  operand 2 per requester.
- req_ctrl  in  NREQ*4  ALU opcode per requester.
- resp_valid  out  NREQ  response valid; one-hot to the owning requester.
- resp_ready  in  NREQ  per-requester response accept.
- resp_data  out  RES_W  result value.
- resp_err  out  1  illegal opcode flag; qualified by resp_valid.
- alu_operand_1  out  OPND_W  to ALU operand_1.
- alu_operand_2  out  OPND_W  to ALU operand_2.
- alu_control  out  4  to ALU alu_control.
- alu_result  in  RES_W  from ALU result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant=1 (requester 0 wins first).
- Reset is synchronous and active-high. Asserting it mid-operation aborts the operation; the in-flight response is dropped and never presented.
- FSM states:
  - IDLE -> ISSUE on legal grant.
  - IDLE -> RESP on illegal grant.
  - ISSUE -> WAIT, unconditionally.
  - WAIT -> RESP, unconditionally.
  - RESP -> IDLE when resp_ready[owner] is high.
- IDLE:
  - req_ready is combinational: the one-hot arbiter grant, and only in IDLE.
  - Handshake occurs when req_valid[i] and req_ready[i] are both high. On that edge, capture owner=i and register op_a, op_b and ctrl.
- Arbitration:
  - Round-robin between requesters.
  - If both are valid, grant the requester that is not last_grant.
  - If one is valid, grant it regardless of last_grant.
  - last_grant updates only on a handshake.
- Legal opcodes are 4'b0001..4'b1011. Opcodes 4'b0000 and 4'b1100..4'b1111 are illegal.
- Illegal opcode path: next state RESP, resp_err=1, resp_data=0; alu_control stays 0.
- ISSUE:
  - alu_operand_1/2 and alu_control hold the captured values.
  - The ALU samples them at the end of ISSUE.
- WAIT:
  - alu_control returns to 0 (ALU holds its result).
  - alu_result is valid during WAIT and is registered into resp_data at the end of WAIT; resp_err=0.
- RESP:
  - resp_valid[owner]=1; resp_data and resp_err are held stable until resp_ready[owner].
  - resp_ready on the non-owner bit is ignored.
- Latency, with the handshake on the edge ending cycle N:
  - Legal opcode: resp_valid is first high in cycle N+3.
  - Illegal opcode: resp_valid is first high in cycle N+1.
- Throughput: one operation at a time.
  - Minimum 4 cycles per legal operation with resp_ready tied high; 2 cycles per illegal operation.
- No new request is accepted in the same cycle as the response handshake; the next accept is in the following IDLE cycle.
- A requester may deassert req_valid before it is granted without side effects.
- Result width: the result is the ALU's 32-bit value unchanged; the controller does no extension or truncation.
- alu_operand_1/2 hold their last issued values outside ISSUE; only alu_control is cleared.

Decomposition:
- alu_pkg holds:
  - opcode localparams: OP_ADD=1, OP_SUB=2, OP_AND=3, OP_SLL=4, OP_SRL=5, OP_AND2=6, OP_OR=7, OP_MUL=8, OP_LT=9, OP_GT=10, OP_EQ=11;
  - function is_legal_op;
  - typedef enum ctrl_state_t {IDLE, ISSUE, WAIT, RESP}.
- One sub-module: rr_arbiter2, holding the combinational grant plus the last_grant register and its update on the handshake.

Test Plan:
- After reset, req 0 issues OP_ADD with a=0x01, b=0x12 -> resp_valid[0] in cycle N+3, resp_data=0x00000013, resp_err=0.
- Req 1 issues OP_SUB with a=0x01, b=0x12 -> resp_valid[1], resp_data=0xFFFFFFEF. During ISSUE: alu_control=4'b0010, alu_operand_1=0x01.
- Both requesters hold valid continuously, with req 0 OP_MUL 31*31 and req 1 OP_EQ 5==5:
  - grants alternate 0,1,0,1;
  - results are 0x000003C1 and 0x00000001;
  - req_ready is never high on both bits.
- Req 0 issues ctrl=4'b1101 -> resp_valid[0] in N+1, resp_err=1, resp_data=0; alu_control stays 0 throughout.
- Backpressure: resp_ready held low for 5 cycles, with req 1 valid -> resp_data stable, req_ready stays 0, busy=1. After resp_ready, req 1 is granted in the next IDLE cycle.
- Assert rst for 1 cycle in WAIT -> the next cycle shows state IDLE, all outputs 0, and no resp_valid for the aborted operation. The following request gets normal latency.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcode encodings, controller state type and opcode legality check
// for the ALU issue controller.
package alu_pkg;

  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] OP_ADD  = 4'd1;
  localparam logic [CTRL_W-1:0] OP_SUB  = 4'd2;
  localparam logic [CTRL_W-1:0] OP_AND  = 4'd3;
  localparam logic [CTRL_W-1:0] OP_SLL  = 4'd4;
  localparam logic [CTRL_W-1:0] OP_SRL  = 4'd5;
  localparam logic [CTRL_W-1:0] OP_AND2 = 4'd6;
  localparam logic [CTRL_W-1:0] OP_OR   = 4'd7;
  localparam logic [CTRL_W-1:0] OP_MUL  = 4'd8;
  localparam logic [CTRL_W-1:0] OP_LT   = 4'd9;
  localparam logic [CTRL_W-1:0] OP_GT   = 4'd10;
  localparam logic [CTRL_W-1:0] OP_EQ   = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ctrl_state_t;

  function automatic logic is_legal_op(input logic [CTRL_W-1:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_SRL, OP_AND2,
      OP_OR, OP_MUL, OP_LT, OP_GT, OP_EQ: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Requester-facing request/response channels of the ALU issue controller.
// master = requester side, slave = controller side.
interface alu_issue_ctrl_if #(
  parameter int NREQ   = 2,
  parameter int OPND_W = 5,
  parameter int RES_W  = 32
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*OPND_W-1:0] req_op_a;
  logic [NREQ*OPND_W-1:0] req_op_b;
  logic [NREQ*4-1:0]      req_ctrl;
  logic [NREQ-1:0]        resp_valid;
  logic [NREQ-1:0]        resp_ready;
  logic [RES_W-1:0]       resp_data;
  logic                   resp_err;

  modport master (
    output req_valid, req_op_a, req_op_b, req_ctrl, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op_a, req_op_b, req_ctrl, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/alu_issue_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant gated by en_i, last_grant
// register updated only on an accepted request. Requester 0 wins first after reset.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o,
  output logic       hs_o,
  output logic       hs_idx_o
);

  logic       last_grant_q;
  logic       last_grant_d;
  logic [1:0] pick;

  always_comb begin
    pick = 2'b00;
    case (valid_i)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_grant_q ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  // Grant is only ever given to a valid requester, so any grant is a handshake.
  assign grant_o  = en_i ? pick : 2'b00;
  assign hs_o     = |grant_o;
  assign hs_idx_o = grant_o[1];

  always_comb begin
    last_grant_d = last_grant_q;
    if (hs_o) begin
      last_grant_d = hs_idx_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one registered ALU between two requesters: round-robin accept, issue,
// wait one cycle for the ALU result, then hold the response until accepted.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int OPND_W = 5,
  parameter int RES_W  = 32,
  parameter int NREQ   = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_ctrl_if.slave     bus,
  output logic [OPND_W-1:0]   alu_operand_1,
  output logic [OPND_W-1:0]   alu_operand_2,
  output logic [CTRL_W-1:0]   alu_control,
  input  logic [RES_W-1:0]    alu_result,
  output logic                busy
);

  ctrl_state_t       state_q, state_d;
  logic              owner_q, owner_d;
  logic [OPND_W-1:0] op_a_q, op_a_d;
  logic [OPND_W-1:0] op_b_q, op_b_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [RES_W-1:0]  resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic              arb_en;
  logic [1:0]        grant;
  logic              hs;
  logic              hs_idx;
  logic [OPND_W-1:0] sel_a;
  logic [OPND_W-1:0] sel_b;
  logic [CTRL_W-1:0] sel_ctrl;
  logic              sel_legal;
  logic [NREQ-1:0]   owner_onehot;

  // Requests are only accepted in IDLE and never while reset is asserted.
  assign arb_en = (state_q == IDLE) && !rst;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .en_i     (arb_en),
    .valid_i  (bus.req_valid),
    .grant_o  (grant),
    .hs_o     (hs),
    .hs_idx_o (hs_idx)
  );

  assign sel_a     = hs_idx ? bus.req_op_a[2*OPND_W-1:OPND_W] : bus.req_op_a[OPND_W-1:0];
  assign sel_b     = hs_idx ? bus.req_op_b[2*OPND_W-1:OPND_W] : bus.req_op_b[OPND_W-1:0];
  assign sel_ctrl  = hs_idx ? bus.req_ctrl[2*CTRL_W-1:CTRL_W] : bus.req_ctrl[CTRL_W-1:0];
  assign sel_legal = is_legal_op(sel_ctrl);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    ctrl_d      = ctrl_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    case (state_q)
      IDLE: begin
        if (hs) begin
          owner_d = hs_idx;
          if (sel_legal) begin
            state_d = ISSUE;
            op_a_d  = sel_a;
            op_b_d  = sel_b;
            ctrl_d  = sel_ctrl;
          end else begin
            // Illegal ops never reach the ALU; operands keep the last issued values.
            state_d     = RESP;
            resp_data_d = '0;
            resp_err_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d     = RESP;
        resp_data_d = alu_result;
        resp_err_d  = 1'b0;
      end
      RESP: begin
        if (bus.resp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      ctrl_q      <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      ctrl_q      <= ctrl_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  always_comb begin
    owner_onehot          = '0;
    owner_onehot[owner_q] = 1'b1;
  end

  assign alu_operand_1  = op_a_q;
  assign alu_operand_2  = op_b_q;
  assign alu_control    = (state_q == ISSUE) ? ctrl_q : '0;

  assign bus.req_ready  = grant;
  assign bus.resp_valid = (state_q == RESP) ? owner_onehot : '0;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural registered ALU attached.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  alu_operand_1;
  logic [4:0]  alu_operand_2;
  logic [3:0]  alu_control;
  logic [31:0] alu_result = '0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_ctrl_if #(.NREQ(2), .OPND_W(5), .RES_W(32)) bus ();

  alu_issue_ctrl #(.OPND_W(5), .RES_W(32), .NREQ(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .alu_operand_1 (alu_operand_1),
    .alu_operand_2 (alu_operand_2),
    .alu_control   (alu_control),
    .alu_result    (alu_result),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Registered ALU: samples when alu_control is non-zero, otherwise holds.
  always @(posedge clk) begin
    logic [31:0] x, y;
    x = {27'b0, alu_operand_1};
    y = {27'b0, alu_operand_2};
    case (alu_control)
      4'd1:  alu_result <= x + y;
      4'd2:  alu_result <= x - y;
      4'd3:  alu_result <= x & y;
      4'd4:  alu_result <= x << y[4:0];
      4'd5:  alu_result <= x >> y[4:0];
      4'd6:  alu_result <= x & y;
      4'd7:  alu_result <= x | y;
      4'd8:  alu_result <= x * y;
      4'd9:  alu_result <= {31'b0, x < y};
      4'd10: alu_result <= {31'b0, x > y};
      4'd11: alu_result <= {31'b0, x == y};
      default: alu_result <= alu_result;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid  = 2'b00;
    bus.req_op_a   = '0;
    bus.req_op_b   = '0;
    bus.req_ctrl   = '0;
    bus.resp_ready = 2'b11;

    // Reset state
    @(negedge clk); #1;
    chk("rst_req_ready", {30'b0, bus.req_ready}, 32'h0);
    chk("rst_resp_valid", {30'b0, bus.resp_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_alu_control", {28'b0, alu_control}, 32'h0);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Req 0 OP_ADD 0x01 + 0x12
    @(negedge clk);
    bus.req_valid = 2'b01; bus.req_op_a = {5'd0, 5'h01}; bus.req_op_b = {5'd0, 5'h12};
    bus.req_ctrl = {4'd0, 4'd1};
    #1; chk("t1_req_ready", {30'b0, bus.req_ready}, 32'h1);
    @(negedge clk); bus.req_valid = 2'b00; #1;
    chk("t1_issue_ctrl", {28'b0, alu_control}, 32'h1);
    chk("t1_busy", {31'b0, busy}, 32'h1);
    chk("t1_no_ready", {30'b0, bus.req_ready}, 32'h0);
    chk("t1_no_valid_n1", {30'b0, bus.resp_valid}, 32'h0);
    @(negedge clk); #1;
    chk("t1_wait_ctrl", {28'b0, alu_control}, 32'h0);
    chk("t1_no_valid_n2", {30'b0, bus.resp_valid}, 32'h0);
    @(negedge clk); #1;
    chk("t1_resp_valid", {30'b0, bus.resp_valid}, 32'h1);
    chk("t1_resp_data", bus.resp_data, 32'h00000013);
    chk("t1_resp_err", {31'b0, bus.resp_err}, 32'h0);

    // Req 1 OP_SUB 0x01 - 0x12
    @(negedge clk);
    bus.req_valid = 2'b10; bus.req_op_a = {5'h01, 5'd0}; bus.req_op_b = {5'h12, 5'd0};
    bus.req_ctrl = {4'd2, 4'd0};
    #1; chk("t2_req_ready", {30'b0, bus.req_ready}, 32'h2);
    @(negedge clk); bus.req_valid = 2'b00; #1;
    chk("t2_issue_ctrl", {28'b0, alu_control}, 32'h2);
    chk("t2_issue_op1", {27'b0, alu_operand_1}, 32'h01);
    chk("t2_issue_op2", {27'b0, alu_operand_2}, 32'h12);
    @(negedge clk);
    @(negedge clk); #1;
    chk("t2_resp_valid", {30'b0, bus.resp_valid}, 32'h2);
    chk("t2_resp_data", bus.resp_data, 32'hFFFFFFEF);
    chk("t2_resp_err", {31'b0, bus.resp_err}, 32'h0);

    // Both requesters valid: req 0 MUL 31*31, req 1 EQ 5==5
    @(negedge clk);
    bus.req_valid = 2'b11; bus.req_op_a = {5'd5, 5'd31}; bus.req_op_b = {5'd5, 5'd31};
    bus.req_ctrl = {4'd11, 4'd8};
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1; chk("t3_grant", {30'b0, bus.req_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
      for (int j = 0; j < 2; j++) begin
        @(negedge clk); #1;
        chk("t3_ready_low", {30'b0, bus.req_ready}, 32'h0);
      end
      @(negedge clk); #1;
      chk("t3_ready_low_resp", {30'b0, bus.req_ready}, 32'h0);
      chk("t3_resp_valid", {30'b0, bus.resp_valid}, (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("t3_resp_data", bus.resp_data, (k % 2 == 0) ? 32'h000003C1 : 32'h00000001);
      if (k == 3) bus.req_valid = 2'b00;
    end

    // Req 0 illegal opcode 4'b1101
    @(negedge clk);
    bus.req_valid = 2'b01; bus.req_ctrl = {4'd0, 4'b1101};
    #1; chk("t4_req_ready", {30'b0, bus.req_ready}, 32'h1);
    chk("t4_ctrl_n", {28'b0, alu_control}, 32'h0);
    @(negedge clk); bus.req_valid = 2'b00; #1;
    chk("t4_resp_valid", {30'b0, bus.resp_valid}, 32'h1);
    chk("t4_resp_err", {31'b0, bus.resp_err}, 32'h1);
    chk("t4_resp_data", bus.resp_data, 32'h0);
    chk("t4_ctrl_n1", {28'b0, alu_control}, 32'h0);
    chk("t4_op1_held", {27'b0, alu_operand_1}, 32'h05);

    // Backpressure: req 0 ADD 2+3, req 1 SUB 3-1 waiting behind it
    @(negedge clk);
    bus.resp_ready = 2'b00;
    bus.req_valid = 2'b01; bus.req_op_a = {5'd3, 5'd2}; bus.req_op_b = {5'd1, 5'd3};
    bus.req_ctrl = {4'd2, 4'd1};
    #1; chk("t5_req_ready", {30'b0, bus.req_ready}, 32'h1);
    @(negedge clk); bus.req_valid = 2'b10; #1;
    chk("t5_ready_issue", {30'b0, bus.req_ready}, 32'h0);
    @(negedge clk); #1;
    chk("t5_ready_wait", {30'b0, bus.req_ready}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.resp_ready = (i > 0) ? 2'b10 : 2'b00;
      #1;
      chk("t5_hold_valid", {30'b0, bus.resp_valid}, 32'h1);
      chk("t5_hold_data", bus.resp_data, 32'h00000005);
      chk("t5_hold_ready", {30'b0, bus.req_ready}, 32'h0);
      chk("t5_hold_busy", {31'b0, busy}, 32'h1);
    end
    @(negedge clk); bus.resp_ready = 2'b01; #1;
    chk("t5_hs_valid", {30'b0, bus.resp_valid}, 32'h1);
    chk("t5_hs_no_accept", {30'b0, bus.req_ready}, 32'h0);
    @(negedge clk); #1;
    chk("t5_next_grant", {30'b0, bus.req_ready}, 32'h2);
    chk("t5_idle_busy", {31'b0, busy}, 32'h0);
    @(negedge clk); bus.req_valid = 2'b00; bus.resp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t5_req1_valid", {30'b0, bus.resp_valid}, 32'h2);
    chk("t5_req1_data", bus.resp_data, 32'h00000002);

    // Reset asserted during WAIT aborts the operation
    @(negedge clk);
    bus.req_valid = 2'b01; bus.req_op_a = {5'd0, 5'd4}; bus.req_op_b = {5'd0, 5'd4};
    bus.req_ctrl = {4'd0, 4'd1};
    #1; chk("t6_req_ready", {30'b0, bus.req_ready}, 32'h1);
    @(negedge clk); bus.req_valid = 2'b00;
    @(negedge clk); #1;
    chk("t6_wait_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("t6_busy", {31'b0, busy}, 32'h0);
    chk("t6_resp_valid", {30'b0, bus.resp_valid}, 32'h0);
    chk("t6_req_ready", {30'b0, bus.req_ready}, 32'h0);
    chk("t6_op1", {27'b0, alu_operand_1}, 32'h0);
    chk("t6_op2", {27'b0, alu_operand_2}, 32'h0);
    chk("t6_ctrl", {28'b0, alu_control}, 32'h0);
    chk("t6_resp_data", bus.resp_data, 32'h0);
    chk("t6_resp_err", {31'b0, bus.resp_err}, 32'h0);
    @(negedge clk);
    bus.req_valid = 2'b01; bus.req_op_a = {5'd0, 5'd7}; bus.req_op_b = {5'd0, 5'd9};
    bus.req_ctrl = {4'd0, 4'd1};
    #1;
    chk("t6_no_stale_resp", {30'b0, bus.resp_valid}, 32'h0);
    chk("t6_new_grant", {30'b0, bus.req_ready}, 32'h1);
    @(negedge clk); bus.req_valid = 2'b00; #1;
    chk("t6_issue_ctrl", {28'b0, alu_control}, 32'h1);
    chk("t6_no_valid_n1", {30'b0, bus.resp_valid}, 32'h0);
    @(negedge clk); #1;
    chk("t6_no_valid_n2", {30'b0, bus.resp_valid}, 32'h0);
    @(negedge clk); #1;
    chk("t6_resp_valid_n3", {30'b0, bus.resp_valid}, 32'h1);
    chk("t6_resp_data_n3", bus.resp_data, 32'h00000010);

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
